fetch_ctrl: RTL

//  PC sequencer and inst-SRAM request controller for the 5-stage pipeline fetch stage.

---
 rtl/fetch_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC sequencer and inst-SRAM request controller with output register and 1-entry skid buffer.
// Optional macro FETCH_ADEL_EN: misaligned fetch PCs raise if_adel and halt fetch until redirected.
module fetch_ctrl #(
  parameter logic [31:0] RESET_ADDR = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall_id,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_add_4,
  output logic [31:0] if_inst,
  output logic        if_adel
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
`ifdef FETCH_ADEL_EN
    , S_HALT = 2'd3
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        discard_q, discard_d;
  logic [31:0] sk_pc_q, sk_pc_d;
  logic [31:0] sk_inst_q, sk_inst_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_pc_add_4_q, if_pc_add_4_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_adel_q, if_adel_d;
  logic        out_free;
  logic        pc_misaligned;

`ifdef FETCH_ADEL_EN
  assign pc_misaligned = (pc_q[1:0] != 2'b00);
`else
  assign pc_misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_ADDR;
      req_pc_q      <= '0;
      discard_q     <= 1'b0;
      sk_pc_q       <= '0;
      sk_inst_q     <= '0;
      if_valid_q    <= 1'b0;
      if_pc_q       <= RESET_ADDR;
      if_pc_add_4_q <= RESET_ADDR + 32'd4;
      if_inst_q     <= '0;
      if_adel_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      discard_q     <= discard_d;
      sk_pc_q       <= sk_pc_d;
      sk_inst_q     <= sk_inst_d;
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_pc_add_4_q <= if_pc_add_4_d;
      if_inst_q     <= if_inst_d;
      if_adel_q     <= if_adel_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    discard_d     = discard_q;
    sk_pc_d       = sk_pc_q;
    sk_inst_d     = sk_inst_q;
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    if_pc_add_4_d = if_pc_add_4_q;
    if_inst_d     = if_inst_q;
    if_adel_d     = if_adel_q;
    out_free      = !if_valid_q || !stall_id;

    if (if_valid_q && !stall_id) if_valid_d = 1'b0;

    if (redirect_valid) begin
      // Skid contents are implicitly dropped: skid is only occupied in HOLD.
      pc_d       = redirect_pc;
      if_valid_d = 1'b0;
      if_adel_d  = 1'b0;
      unique case (state_q)
        S_REQ: begin
          if (inst_req && inst_addr_ok) begin
            discard_d = 1'b1;
            state_d   = S_WAIT;
          end
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            discard_d = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (pc_misaligned) begin
`ifdef FETCH_ADEL_EN
            if (out_free) begin
              if_valid_d    = 1'b1;
              if_pc_d       = pc_q;
              if_pc_add_4_d = pc_q + 32'd4;
              if_inst_d     = '0;
              if_adel_d     = 1'b1;
              state_d       = S_HALT;
            end
`endif
          end else if (inst_addr_ok) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = S_REQ;
            end else if (out_free) begin
              if_valid_d    = 1'b1;
              if_pc_d       = req_pc_q;
              if_pc_add_4_d = req_pc_q + 32'd4;
              if_inst_d     = inst_rdata;
              if_adel_d     = 1'b0;
              state_d       = S_REQ;
            end else begin
              sk_pc_d   = req_pc_q;
              sk_inst_d = inst_rdata;
              state_d   = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall_id) begin
            if_valid_d    = 1'b1;
            if_pc_d       = sk_pc_q;
            if_pc_add_4_d = sk_pc_q + 32'd4;
            if_inst_d     = sk_inst_q;
            if_adel_d     = 1'b0;
            state_d       = S_REQ;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    inst_req    = (state_q == S_REQ) && !pc_misaligned;
`ifdef FETCH_ADEL_EN
    inst_addr   = pc_q;
`else
    inst_addr   = {pc_q[31:2], 2'b00};
`endif
    if_valid    = if_valid_q;
    if_pc       = if_pc_q;
    if_pc_add_4 = if_pc_add_4_q;
    if_inst     = if_inst_q;
    if_adel     = if_adel_q;
  end

endmodule
